program_counter: RTL and testbench

Sequential program counter for the CPU datapath. It supplies the instruction-memory address each cycle and takes jump targets from the ALU/A-register path through a 16-bit loadable register stage. It adds increment, load, and hold, plus a small hardware return-address stack for call/return. Overflow and underflow of that stack are reported through sticky flags.

---
 rtl/program_counter_pkg.sv | 29 ++
 rtl/program_counter_if.sv | 22 ++
 rtl/program_counter_return_stack.sv | 49 ++++
 rtl/program_counter.sv | 77 +++++++
 tb/tb_program_counter.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/program_counter_pkg.sv
// Shared defaults and the priority-encoded command selector for the program counter.
package program_counter_pkg;

    localparam int PC_WIDTH = 16;
    localparam int PC_DEPTH = 4;

    // Command chosen for the current edge, highest priority first.
    typedef enum logic [2:0] {
        CMD_RST  = 3'd0,
        CMD_RET  = 3'd1,
        CMD_CALL = 3'd2,
        CMD_LOAD = 3'd3,
        CMD_INC  = 3'd4,
        CMD_HOLD = 3'd5
    } cmd_e;

    // Fixed-priority encoder. Lower-priority requests are dropped.
    function automatic cmd_e encode_cmd(input logic i_reset, input logic i_ret,
                                        input logic i_call, input logic i_load,
                                        input logic i_inc);
        if (i_reset)     return CMD_RST;
        else if (i_ret)  return CMD_RET;
        else if (i_call) return CMD_CALL;
        else if (i_load) return CMD_LOAD;
        else if (i_inc)  return CMD_INC;
        else             return CMD_HOLD;
    endfunction

endpackage

// File: rtl/program_counter_if.sv
// Command/status bundle between the sequencer (master) and the program counter (slave).
interface program_counter_if
    import program_counter_pkg::*;
#(
    parameter int WIDTH = PC_WIDTH,
    parameter int DEPTH = PC_DEPTH
) ();
    localparam int DW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] in;
    logic             load;
    logic             inc;
    logic             call;
    logic             ret;
    logic [WIDTH-1:0] out;
    logic [DW-1:0]    depth;
    logic             ovf;
    logic             unf;

    modport master (output in, load, inc, call, ret, input out, depth, ovf, unf);
    modport slave  (input in, load, inc, call, ret, output out, depth, ovf, unf);
endinterface

// File: rtl/program_counter_return_stack.sv
// Return-address LIFO. Caller must never push when full or pop when empty.
module return_stack
    import program_counter_pkg::*;
#(
    parameter int WIDTH = PC_WIDTH,
    parameter int DEPTH = PC_DEPTH,
    parameter int DW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic [DW-1:0]    depth,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DW-1:0]    r_depth;
    logic [WIDTH-1:0] w_top;

    // Push writes the slot at the current depth; pop just lowers the pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_depth <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (push && !full) begin
            for (int i = 0; i < DEPTH; i++)
                if (r_depth == DW'(i)) r_mem[i] <= din;
            r_depth <= r_depth + 1'b1;
        end else if (pop && !empty) begin
            r_depth <= r_depth - 1'b1;
        end
    end

    // Top-of-stack mux on registered state, so consecutive pops see distinct entries.
    always_comb begin
        w_top = '0;
        for (int i = 0; i < DEPTH; i++)
            if (r_depth == DW'(i + 1)) w_top = r_mem[i];
    end

    assign top   = w_top;
    assign depth = r_depth;
    assign full  = (r_depth == DW'(DEPTH));
    assign empty = (r_depth == '0);

endmodule

// File: rtl/program_counter.sv
// Program counter: jump/increment/hold plus call/return through a hardware return stack.
module program_counter
    import program_counter_pkg::*;
#(
    parameter int WIDTH = PC_WIDTH,
    parameter int DEPTH = PC_DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    program_counter_if.slave   bus
);
    localparam int DW = $clog2(DEPTH + 1);

    cmd_e             w_cmd;
    logic [WIDTH-1:0] r_out;
    logic             r_ovf;
    logic             r_unf;
    logic [WIDTH-1:0] w_out_inc;
    logic [WIDTH-1:0] w_top;
    logic [DW-1:0]    w_depth;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    // Resolve the single command that wins this edge.
    always_comb begin
        w_cmd = encode_cmd(reset, bus.ret, bus.call, bus.load, bus.inc);
    end

    // Wraps modulo 2^WIDTH; shared by increment and return-address push.
    assign w_out_inc = r_out + 1'b1;

    // A call on a full stack still jumps but drops the push; a ret on empty does nothing.
    assign w_push = (w_cmd == CMD_CALL) && !w_full;
    assign w_pop  = (w_cmd == CMD_RET)  && !w_empty;

    return_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DW(DW)) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_out_inc),
        .top   (w_top),
        .depth (w_depth),
        .full  (w_full),
        .empty (w_empty)
    );

    // Address register and sticky overflow/underflow flags; only reset clears the flags.
    always_ff @(posedge clk) begin
        case (w_cmd)
            CMD_RST: begin
                r_out <= '0;
                r_ovf <= 1'b0;
                r_unf <= 1'b0;
            end
            CMD_RET: begin
                if (w_empty) r_unf <= 1'b1;
                else         r_out <= w_top;
            end
            CMD_CALL: begin
                r_out <= bus.in;
                if (w_full) r_ovf <= 1'b1;
            end
            CMD_LOAD: r_out <= bus.in;
            CMD_INC:  r_out <= w_out_inc;
            default:  ;
        endcase
    end

    assign bus.out   = r_out;
    assign bus.depth = w_depth;
    assign bus.ovf   = r_ovf;
    assign bus.unf   = r_unf;

endmodule

// File: tb/tb_program_counter.sv
// Directed table-driven bench for program_counter plus a few hand-written sequences.
module tb_program_counter;
    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;

    program_counter_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) pc_if ();

    program_counter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (pc_if.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rt;
        logic        cl;
        logic        ld;
        logic        ic;
        logic [15:0] din;
        logic [15:0] e_out;
        logic [2:0]  e_dep;
        logic        e_ovf;
        logic        e_unf;
        string       name;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(string nm, logic rst, logic rt, logic cl, logic ld, logic ic,
                                logic [15:0] din, logic [15:0] eo, logic [2:0] ed,
                                logic eov, logic eun);
        vec_t v;
        v.name = nm; v.rst = rst; v.rt = rt; v.cl = cl; v.ld = ld; v.ic = ic;
        v.din = din; v.e_out = eo; v.e_dep = ed; v.e_ovf = eov; v.e_unf = eun;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic rt, input logic cl, input logic ld,
                         input logic ic, input logic [15:0] din);
        reset = rst; pc_if.ret = rt; pc_if.call = cl; pc_if.load = ld; pc_if.inc = ic;
        pc_if.in = din;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string nm, input logic [15:0] eo, input logic [2:0] ed,
                           input logic eov, input logic eun);
        chk({nm, ".out"},   32'(pc_if.out),   32'(eo));
        chk({nm, ".depth"}, 32'(pc_if.depth), 32'(ed));
        chk({nm, ".ovf"},   32'(pc_if.ovf),   32'(eov));
        chk({nm, ".unf"},   32'(pc_if.unf),   32'(eun));
    endtask

    initial begin
        reset = 1'b0; pc_if.ret = 1'b0; pc_if.call = 1'b0; pc_if.load = 1'b0;
        pc_if.inc = 1'b0; pc_if.in = '0;

        //                 name        rst ret cal ld  inc in        out      dep ovf unf
        vecs.push_back(mk("reset",      1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk("hold",   0, 0, 0, 0, 0, 16'h5A5A, 16'h0000, 0, 0, 0));
        vecs.push_back(mk("ld_fffe",    0, 0, 0, 1, 0, 16'hFFFE, 16'hFFFE, 0, 0, 0));
        vecs.push_back(mk("inc_ffff",   0, 0, 0, 0, 1, 16'h0000, 16'hFFFF, 0, 0, 0));
        vecs.push_back(mk("inc_wrap",   0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0));
        vecs.push_back(mk("ld_over_inc",0, 0, 0, 1, 1, 16'h1234, 16'h1234, 0, 0, 0));
        vecs.push_back(mk("rst_over_all",1,1, 1, 0, 0, 16'h4444, 16'h0000, 0, 0, 0));
        vecs.push_back(mk("ld_0010",    0, 0, 0, 1, 0, 16'h0010, 16'h0010, 0, 0, 0));
        vecs.push_back(mk("call_0100",  0, 0, 1, 0, 0, 16'h0100, 16'h0100, 1, 0, 0));
        vecs.push_back(mk("call_0200",  0, 0, 1, 1, 1, 16'h0200, 16'h0200, 2, 0, 0));
        vecs.push_back(mk("ret_0101",   0, 1, 1, 1, 0, 16'h0999, 16'h0101, 1, 0, 0));
        vecs.push_back(mk("ret_0011",   0, 1, 0, 0, 0, 16'h0000, 16'h0011, 0, 0, 0));
        vecs.push_back(mk("call1",      0, 0, 1, 0, 0, 16'h1000, 16'h1000, 1, 0, 0));
        vecs.push_back(mk("call2",      0, 0, 1, 0, 0, 16'h2000, 16'h2000, 2, 0, 0));
        vecs.push_back(mk("call3",      0, 0, 1, 0, 0, 16'h3000, 16'h3000, 3, 0, 0));
        vecs.push_back(mk("call4",      0, 0, 1, 0, 0, 16'h4000, 16'h4000, 4, 0, 0));
        vecs.push_back(mk("call5_ovf",  0, 0, 1, 0, 0, 16'h5000, 16'h5000, 4, 1, 0));
        vecs.push_back(mk("ret1",       0, 1, 0, 0, 0, 16'h0000, 16'h3001, 3, 1, 0));
        vecs.push_back(mk("ret2",       0, 1, 0, 0, 0, 16'h0000, 16'h2001, 2, 1, 0));
        vecs.push_back(mk("ret3",       0, 1, 0, 0, 0, 16'h0000, 16'h1001, 1, 1, 0));
        vecs.push_back(mk("ret4",       0, 1, 0, 0, 0, 16'h0000, 16'h0012, 0, 1, 0));
        vecs.push_back(mk("ret5_unf",   0, 1, 0, 0, 0, 16'h0000, 16'h0012, 0, 1, 1));
        vecs.push_back(mk("sticky_inc", 0, 0, 0, 0, 1, 16'h0000, 16'h0013, 0, 1, 1));
        vecs.push_back(mk("sticky_ld",  0, 0, 0, 1, 0, 16'h0777, 16'h0777, 0, 1, 1));
        vecs.push_back(mk("rst2",       1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0));
        vecs.push_back(mk("mcall1",     0, 0, 1, 0, 0, 16'h0AAA, 16'h0AAA, 1, 0, 0));
        vecs.push_back(mk("mcall2",     0, 0, 1, 0, 0, 16'h0BBB, 16'h0BBB, 2, 0, 0));
        vecs.push_back(mk("mid_rst",    1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0));
        vecs.push_back(mk("ret_after",  0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 1));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].rt, vecs[i].cl, vecs[i].ld, vecs[i].ic, vecs[i].din);
            chk_all(vecs[i].name, vecs[i].e_out, vecs[i].e_dep, vecs[i].e_ovf, vecs[i].e_unf);
        end

        // Return address wraps: call from 0xFFFF pushes 0x0000.
        drive(1, 0, 0, 0, 0, 16'h0000);
        drive(0, 0, 0, 1, 0, 16'hFFFF);
        chk_all("wrap_ld", 16'hFFFF, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 16'h0300);
        chk_all("wrap_call", 16'h0300, 1, 0, 0);
        drive(0, 1, 0, 0, 0, 16'h0000);
        chk_all("wrap_ret", 16'h0000, 0, 0, 0);

        // Back-to-back call/ret from a mid-range address, then a long idle hold.
        drive(0, 0, 0, 1, 0, 16'h4321);
        drive(0, 0, 1, 0, 0, 16'h8000);
        chk_all("b2b_call", 16'h8000, 1, 0, 0);
        drive(0, 1, 0, 0, 0, 16'h0000);
        chk_all("b2b_ret", 16'h4322, 0, 0, 0);
        for (int i = 0; i < 20; i++) drive(0, 0, 0, 0, 0, 16'($urandom_range(0, 65535)));
        chk_all("long_hold", 16'h4322, 0, 0, 0);

        // Stack entries survive an idle stretch and pop in LIFO order.
        drive(0, 0, 1, 0, 0, 16'h0040);
        drive(0, 0, 1, 0, 0, 16'h0050);
        for (int i = 0; i < 7; i++) drive(0, 0, 0, 0, 0, 16'h0000);
        chk_all("idle_stack", 16'h0050, 2, 0, 0);
        drive(0, 1, 0, 0, 0, 16'h0000);
        chk_all("idle_ret1", 16'h0041, 1, 0, 0);
        drive(0, 1, 0, 0, 0, 16'h0000);
        chk_all("idle_ret2", 16'h4323, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
